// File: rtl/gb_sound_pkg.sv
// Shared sound constants for the channel modules and the mixer.
package gb_sound_pkg;
  localparam int unsigned VOL_W    = 4;
  localparam int unsigned PERIOD_W = 3;
  localparam int unsigned LEN_W    = 6;
  localparam int unsigned VOL_MAX  = 15;
  localparam int unsigned VOL_MIN  = 0;
endpackage

// File: rtl/envelope_unit_rise_detect.sv
// Rising-edge detector for signals already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);
  logic in_q;

  always_ff @(posedge clk) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;
endmodule

// File: rtl/envelope_unit.sv
// Volume envelope for one sound channel, stepped by the 64 Hz timer tick.
// Optional length counter enabled by defining ENV_LENGTH_EN.
module envelope_unit #(
  parameter int unsigned VOL_W    = gb_sound_pkg::VOL_W,
  parameter int unsigned PERIOD_W = gb_sound_pkg::PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                env_tick,
  input  logic                trigger,
  input  logic [VOL_W-1:0]    init_volume,
  input  logic                env_add,
  input  logic [PERIOD_W-1:0] env_period,
`ifdef ENV_LENGTH_EN
  input  logic                length_tick,
  input  logic [gb_sound_pkg::LEN_W-1:0] length_load,
  input  logic                length_en,
  output logic                channel_on,
`endif
  output logic [VOL_W-1:0]    volume,
  output logic                active
);
  import gb_sound_pkg::*;

  localparam logic [VOL_W-1:0]    LIM_HI  = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0]    LIM_LO  = VOL_W'(VOL_MIN);
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic                tick_rise;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                add_q, add_d;
  logic                running_q, running_d;

  rise_detect u_env_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (env_tick),
    .rise  (tick_rise)
  );

  always_comb begin
    vol_d     = vol_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    add_d     = add_q;
    running_d = running_q;
    if (trigger) begin
      vol_d     = init_volume;
      period_d  = env_period;
      cnt_d     = env_period;
      add_d     = env_add;
      running_d = (env_period != '0);
    end else if (tick_rise && running_q) begin
      if (cnt_q > CNT_ONE) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = period_q;
        if (add_q && vol_q != LIM_HI)
          vol_d = vol_q + VOL_W'(1);
        else if (!add_q && vol_q != LIM_LO)
          vol_d = vol_q - VOL_W'(1);
        // Freeze as soon as the limit is reached, so cnt never counts past it
        if ((add_q && vol_d == LIM_HI) || (!add_q && vol_d == LIM_LO))
          running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vol_q     <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      add_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      vol_q     <= vol_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      add_q     <= add_d;
      running_q <= running_d;
    end
  end

  assign active = running_q;

`ifdef ENV_LENGTH_EN
  logic       len_rise;
  logic [6:0] len_q, len_d;
  logic       on_q, on_d;

  rise_detect u_len_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (length_tick),
    .rise  (len_rise)
  );

  always_comb begin
    len_d = len_q;
    on_d  = on_q;
    if (trigger) begin
      len_d = 7'd64 - {1'b0, length_load};
      on_d  = 1'b1;
    end else if (len_rise && length_en && len_q != '0) begin
      len_d = len_q - 7'd1;
      if (len_d == '0) on_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= '0;
      on_q  <= 1'b0;
    end else begin
      len_q <= len_d;
      on_q  <= on_d;
    end
  end

  assign channel_on = on_q;
  assign volume     = on_q ? vol_q : '0;
`else
  assign volume = vol_q;
`endif
endmodule
